// File: rtl/ysyx_22050019_dcache_pkg.sv
// Shared types and constants for the LSU data cache: FSM state encoding,
// AXI response codes and line geometry.
package ysyx_22050019_dcache_pkg;

    localparam int ADDR_W     = 64;
    localparam int OFFSET_W   = 3;
    localparam int LINE_W     = 64;
    localparam int LINE_BYTES = LINE_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_AR,
        ST_MISS_R,
        ST_RESP
    } state_e;

endpackage

// File: rtl/ysyx_22050019_dcache_if.sv
// AXI-lite read channel pair (AR + R). The cache is a slave towards the LSU
// and a master towards the arbiter, so the same bundle is used on both sides.
interface ysyx_22050019_dcache_if;
    import ysyx_22050019_dcache_pkg::*;

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [1:0]        r_resp;
    logic [LINE_W-1:0] r_data;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_resp, r_data
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_resp, r_data
    );

endinterface

// File: rtl/ysyx_22050019_dcache_array.sv
// Line storage: valid/tag/data per set. One asynchronous read port for the
// lookup, one fill write port, and one byte-masked snoop merge port. When a
// fill and a snoop target the same set in one cycle, the snoop is evaluated
// against the freshly filled line so its bytes land on top of the fill.
module ysyx_22050019_dcache_array
    import ysyx_22050019_dcache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int IDX   = $clog2(SETS),
    parameter int TAG_W = ADDR_W - IDX - OFFSET_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // lookup
    input  logic [IDX-1:0]        rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_data,
    // refill install
    input  logic                  fill_en,
    input  logic [IDX-1:0]        fill_idx,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [LINE_W-1:0]     fill_data,
    // store snoop
    input  logic                  snp_en,
    input  logic [IDX-1:0]        snp_idx,
    input  logic [TAG_W-1:0]      snp_tag,
    input  logic [LINE_W-1:0]     snp_data,
    input  logic [LINE_BYTES-1:0] snp_strb
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    logic              w_same_idx;
    logic              w_base_valid;
    logic [TAG_W-1:0]  w_base_tag;
    logic [LINE_W-1:0] w_base_data;
    logic [LINE_W-1:0] w_merged;
    logic              w_snp_hit;

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

    // Snoop hit test sees the line as it will be after this cycle's fill.
    always_comb begin
        w_same_idx   = fill_en && (fill_idx == snp_idx);
        w_base_valid = w_same_idx || r_valid[snp_idx];
        w_base_tag   = w_same_idx ? fill_tag  : r_tag[snp_idx];
        w_base_data  = w_same_idx ? fill_data : r_data[snp_idx];
        w_snp_hit    = snp_en && w_base_valid && (w_base_tag == snp_tag);
    end

    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
            assign w_merged[gi*8 +: 8] = snp_strb[gi] ? snp_data[gi*8 +: 8]
                                                      : w_base_data[gi*8 +: 8];
        end
    endgenerate

    // Valid bits: cleared asynchronously, set by a fill; snoops never allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data: fill first, then the snoop merge overrides (merge already
    // includes the fill data when both hit the same set).
    always_ff @(posedge clk) begin
        if (fill_en) begin
            r_tag[fill_idx]  <= fill_tag;
            r_data[fill_idx] <= fill_data;
        end
        if (w_snp_hit) begin
            r_data[snp_idx] <= w_merged;
        end
    end

endmodule

// File: rtl/ysyx_22050019_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache on the LSU read
// path. One read outstanding; misses fetch one aligned doubleword. Completed
// store beats are snooped and byte-merged into resident lines.
// Optional build macro: YSYX_22050019_DCACHE_MMIO_BYPASS_EN makes addresses
// with addr[31] == 0 uncacheable (forced miss, no install, snoops ignored).
module ysyx_22050019_dcache
    import ysyx_22050019_dcache_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_22050019_dcache_if.slave  s_bus,
    ysyx_22050019_dcache_if.master m_bus,
    input  logic                   snp_valid,
    input  logic [ADDR_W-1:0]      snp_addr,
    input  logic [LINE_W-1:0]      snp_data,
    input  logic [LINE_BYTES-1:0]  snp_strb
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX - OFFSET_W;

    state_e                       r_state;
    logic [ADDR_W-1:OFFSET_W]     r_addr;
    logic                         r_ar_ready;
    logic                         r_r_valid;
    logic [1:0]                   r_r_resp;
    logic [LINE_W-1:0]            r_r_data;
    logic                         r_m_ar_valid;
    logic                         r_m_r_ready;
    logic                         r_stale;

    logic                         w_rd_valid;
    logic [TAG_W-1:0]             w_rd_tag;
    logic [LINE_W-1:0]            w_rd_data;
    logic                         w_cacheable;
    logic                         w_snp_cacheable;
    logic                         w_hit;
    logic                         w_fill_en;
    logic                         w_snp_en;
    logic                         w_snp_same;
    logic                         w_unused_ok;

`ifdef YSYX_22050019_DCACHE_MMIO_BYPASS_EN
    assign w_cacheable     = r_addr[31];
    assign w_snp_cacheable = snp_addr[31];
`else
    assign w_cacheable     = 1'b1;
    assign w_snp_cacheable = 1'b1;
`endif

    // Byte offsets play no part in lookup or snoop matching.
    assign w_unused_ok = &{1'b0, s_bus.ar_addr[OFFSET_W-1:0], snp_addr[OFFSET_W-1:0]};

    assign w_hit      = w_rd_valid && (w_rd_tag == r_addr[ADDR_W-1:IDX+OFFSET_W]) && w_cacheable;
    assign w_fill_en  = (r_state == ST_MISS_R) && r_m_r_ready && m_bus.r_valid
                        && (m_bus.r_resp == RESP_OKAY) && !r_stale && w_cacheable;
    assign w_snp_en   = snp_valid && w_snp_cacheable;
    assign w_snp_same = snp_valid && (snp_addr[ADDR_W-1:OFFSET_W] == r_addr);

    assign s_bus.ar_ready = r_ar_ready;
    assign s_bus.r_valid  = r_r_valid;
    assign s_bus.r_resp   = r_r_resp;
    assign s_bus.r_data   = r_r_data;
    assign m_bus.ar_valid = r_m_ar_valid;
    assign m_bus.ar_addr  = {r_addr, {OFFSET_W{1'b0}}};
    assign m_bus.r_ready  = r_m_r_ready;

    ysyx_22050019_dcache_array #(
        .SETS (SETS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (r_addr[IDX+OFFSET_W-1:OFFSET_W]),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_data   (w_rd_data),
        .fill_en   (w_fill_en),
        .fill_idx  (r_addr[IDX+OFFSET_W-1:OFFSET_W]),
        .fill_tag  (r_addr[ADDR_W-1:IDX+OFFSET_W]),
        .fill_data (m_bus.r_data),
        .snp_en    (w_snp_en),
        .snp_idx   (snp_addr[IDX+OFFSET_W-1:OFFSET_W]),
        .snp_tag   (snp_addr[ADDR_W-1:IDX+OFFSET_W]),
        .snp_data  (snp_data),
        .snp_strb  (snp_strb)
    );

    // Request FSM. Each handshake output is raised one edge after entering its
    // state and dropped on the handshake edge, so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_ar_ready   <= 1'b0;
            r_r_valid    <= 1'b0;
            r_r_resp     <= 2'b00;
            r_r_data     <= '0;
            r_m_ar_valid <= 1'b0;
            r_m_r_ready  <= 1'b0;
            r_stale      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stale <= 1'b0;
                    if (!r_ar_ready) begin
                        r_ar_ready <= 1'b1;
                    end else if (s_bus.ar_valid) begin
                        r_ar_ready <= 1'b0;
                        r_addr     <= s_bus.ar_addr[ADDR_W-1:OFFSET_W];
                        r_state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_r_data <= w_rd_data;
                        r_r_resp <= RESP_OKAY;
                        r_state  <= ST_RESP;
                    end else begin
                        r_state  <= ST_MISS_AR;
                    end
                end
                ST_MISS_AR: begin
                    if (w_snp_same) begin
                        r_stale <= 1'b1;
                    end
                    if (!r_m_ar_valid) begin
                        r_m_ar_valid <= 1'b1;
                    end else if (m_bus.ar_ready) begin
                        r_m_ar_valid <= 1'b0;
                        r_state      <= ST_MISS_R;
                    end
                end
                ST_MISS_R: begin
                    if (w_snp_same) begin
                        r_stale <= 1'b1;
                    end
                    if (!r_m_r_ready) begin
                        r_m_r_ready <= 1'b1;
                    end else if (m_bus.r_valid) begin
                        r_m_r_ready <= 1'b0;
                        r_r_data    <= m_bus.r_data;
                        r_r_resp    <= m_bus.r_resp;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!r_r_valid) begin
                        r_r_valid <= 1'b1;
                    end else if (s_bus.r_ready) begin
                        r_r_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_22050019_dcache.md
# ysyx_22050019_dcache

Direct-mapped, write-through, no-write-allocate data cache on the LSU read path, between the LSU AXI-lite read master and the arbiter's slave-2 read port. Read misses fetch one aligned 64-bit word from the arbiter and install it. Stores bypass the cache on their own channel; the block snoops each completed store beat and byte-merges it into a resident line. One read is outstanding at a time, matching the in-order LSU.

## Interface
- SETS, 64, number of lines; power of two, ≥2; IDX = log2(SETS)
- RESP_OKAY, 2'b00, response code that allows a line fill
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- s_ar_valid  in  1  LSU read request
- s_ar_ready  out  1  cache accepts request
- s_ar_addr  in  64  byte address; bits [2:0] ignored for lookup
- s_r_valid  out  1  read data valid to LSU
- s_r_ready  in  1  LSU accepts data
- s_r_resp  out  2  response code to LSU
- s_r_data  out  64  aligned doubleword; LSU extracts the sub-word
- m_ar_valid  out  1  refill request to the arbiter
- m_ar_ready  in  1  arbiter accepts the request
- m_ar_addr  out  64  {s_ar_addr[63:3], 3'b0}
- m_r_valid  in  1  refill data valid
- m_r_ready  out  1  cache accepts refill data
- m_r_resp  in  2  refill response code
- m_r_data  in  64  refill doubleword
- snp_valid  in  1  store beat completed downstream (w_valid & w_ready)
- snp_addr  in  64  store address
- snp_data  in  64  store data, doubleword-aligned lanes
- snp_strb  in  8  byte enables

## Operation
- Address split:
  - offset = [2:0]
  - index = [IDX+2:3]
  - tag = [63:IDX+3]
- Each line stores: valid, tag, and 64 bits of data.
- FSM states: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
- IDLE:
  - s_ar_ready = 1.
  - On the s_ar handshake, register the address and go to LOOKUP.
- LOOKUP:
  - Read the line at the registered index.
  - Hit (valid and tag match): latch the line data, set resp = OKAY, go to RESP.
  - Miss: go to MISS_AR.
- MISS_AR:
  - Hold m_ar_valid = 1 with a stable m_ar_addr until m_ar_ready.
  - Then go to MISS_R.
- MISS_R:
  - m_r_ready = 1.
  - On m_r_valid, latch m_r_data and m_r_resp, then go to RESP.
  - Install the line only if m_r_resp == RESP_OKAY and the stale flag is clear.
- RESP:
  - Hold s_r_valid with stable data and resp until s_r_ready.
  - Then go to IDLE.
- Snoop:
  - On snp_valid, if the line at snp_addr's index is valid and its tag matches, write each byte where snp_strb is 1.
  - Never allocates a line.
- Snoop during MISS_AR or MISS_R to the same doubleword as the pending miss sets the stale flag. Data is still returned to the LSU, but no fill occurs. The flag clears in IDLE.
- Snoop and fill to the same index in the same cycle: the fill is applied first, then the snoop merge.
- Reset mid-transaction:
  - Abandon everything, clear all valid bits, return to IDLE.
  - Any outstanding downstream beat is dropped by the arbiter's own reset.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - all valid bits 0
- s_ar_ready is registered: 0 during reset, 1 from the first clk edge after rst_n deasserts.
- Hit latency: AR handshake at edge N, s_r_valid high after edge N+2.
- Miss latency:
  - m_ar_valid is high after edge N+2.
  - s_r_valid follows one cycle after the m_r handshake.
- LOOKUP reads the array value from before the edge. A snoop on the same edge becomes visible to the next request.
- No combinational path exists from any input to any output.

## Configuration
- YSYX_22050019_DCACHE_MMIO_BYPASS_EN defined:
  - Addresses with addr[31] == 0 (below 0x8000_0000) are uncacheable.
  - LOOKUP forces a miss; the refill is forwarded but never installed.
  - Snoops to these addresses are ignored.
- Undefined: every address is cacheable.

## Structure
- Package ysyx_22050019_dcache_pkg holds:
  - FSM state enum
  - RESP_OKAY / RESP_SLVERR constants
  - OFFSET_W = 3 and line-width constants
- Sub-module ysyx_22050019_dcache_array holds the valid/tag/data registers. It has:
  - one async read port
  - one fill write port
  - one byte-masked snoop write port, applied after the fill
  - async clear of valid on rst_n

## Test plan
- Cold read 0x8000_0010, refill data 0x1122334455667788 -> m_ar_addr 0x8000_0010; s_r_data 0x1122334455667788, resp 0.
- Repeat read 0x8000_0014 -> no m_ar_valid; s_r_valid at N+2 with the same data.
- Snoop 0x8000_0010, strb 0x0F, data 0xAAAAAAAA_BBBBBBBB, then read -> 0x11223344_BBBBBBBB, no refill.
- Read 0x8000_0210 (SETS = 64, same index) -> miss and refill, evicting the line; a later read of 0x8000_0010 misses again.
- Refill with m_r_resp = 2'b10 -> s_r_resp 2'b10; the next read of that address misses again.
- Stall cases:
  - s_r_ready held low 5 cycles -> s_r_valid and data stable throughout.
  - m_ar_ready held low 3 cycles -> m_ar_valid and m_ar_addr stable throughout.
  - rst_n pulsed in MISS_R -> IDLE, all lines invalid.
